// File: rtl/pmp_dmp.sv
// PMP checker with Domain Memory Protection: checks one access against prioritized
// regions, each owned by a domain, giving a combinational and a registered permit.
module pmp_dmp #(
    parameter int unsigned PLEN       = 34,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [PLEN-1:0]                     addr_i,
    input  logic [2:0]                          access_type_i,
    input  logic [1:0]                          priv_lvl_i,
    input  logic [1:0]                          curdom_i,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  conf_addr_i,
    input  logic [NR_ENTRIES-1:0][7:0]          pmpconf_i,
    input  logic [NR_ENTRIES-1:0][7:0]          dmpconf_i,
    output logic                                allow_o,
    output logic                                allow_q_o
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_TOR   = 2'd1,
        MODE_NA4   = 2'd2,
        MODE_NAPOT = 2'd3
    } addr_mode_e;

    typedef struct packed {
        logic       locked;
        logic [1:0] rsvd;
        addr_mode_e mode;
        logic [2:0] access;
    } pmpcfg_t;

    localparam logic [1:0] PRIV_M = 2'd3;
    localparam logic [1:0] DOM_I  = 2'd3;

    // Compare in a width that holds both the address and a shifted pmpaddr, so no bits are lost.
    localparam int unsigned AW = (PMP_LEN + 2 > PLEN) ? PMP_LEN + 2 : PLEN;

    logic allow_d, allow_q;

    if (NR_ENTRIES == 0) begin : g_no_entries
        logic unused_inputs;
        assign unused_inputs = ^{addr_i, access_type_i, priv_lvl_i, curdom_i,
                                 conf_addr_i, pmpconf_i, dmpconf_i};
        assign allow_d = 1'b1;
    end else begin : g_entries
        logic [AW-1:0]         addr_w;
        logic [NR_ENTRIES-1:0] match;
        logic [NR_ENTRIES-1:0] pass;
        logic [NR_ENTRIES-1:0] locked;
        logic                  hit, hit_pass, hit_locked;

        assign addr_w = AW'(addr_i);

        for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
            pmpcfg_t            cfg;
            logic [AW-1:0]      hi, lo, dc_mask;
            logic [PMP_LEN-1:0] napot_ones;
            logic               perm_ok, dom_ok;
            logic               unused_rsvd;

            assign cfg = pmpcfg_t'(pmpconf_i[i]);
            assign hi  = AW'(conf_addr_i[i]) << 2;
            if (i == 0) begin : g_lo_zero
                assign lo = '0;
            end else begin : g_lo_prev
                assign lo = AW'(conf_addr_i[i-1]) << 2;
            end

            // x ^ (x+1) sets the trailing ones plus the first zero: exactly bits 0..t of the region.
            assign napot_ones = conf_addr_i[i] ^ (conf_addr_i[i] + PMP_LEN'(1));
            assign dc_mask    = AW'({napot_ones, 2'b11});

            always_comb begin
                // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
                match[i] = 1'b0;
                unique case (cfg.mode)
                    MODE_OFF:   match[i] = 1'b0;
                    MODE_TOR:   match[i] = (hi > lo) && (addr_w >= lo) && (addr_w < hi);
                    MODE_NA4:   match[i] = (addr_w >> 2) == AW'(conf_addr_i[i]);
                    MODE_NAPOT: match[i] = (&conf_addr_i[i]) || (((addr_w ^ hi) & ~dc_mask) == '0);
                    default:    match[i] = 1'b0;
                endcase
            end

            assign perm_ok     = (access_type_i & cfg.access) == access_type_i;
            assign dom_ok      = (dmpconf_i[i][1:0] == curdom_i) || (dmpconf_i[i][1:0] == DOM_I);
            assign pass[i]     = perm_ok && dom_ok;
            assign locked[i]   = cfg.locked;
            assign unused_rsvd = ^{cfg.rsvd, dmpconf_i[i][7:2]};
        end

        // Walk from highest to lowest index so the lowest-index match overwrites the rest.
        always_comb begin
            hit        = 1'b0;
            hit_pass   = 1'b0;
            hit_locked = 1'b0;
            for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
                if (match[i]) begin
                    hit        = 1'b1;
                    hit_pass   = pass[i];
                    hit_locked = locked[i];
                end
            end
        end

        always_comb begin
            if (priv_lvl_i == PRIV_M) begin
                allow_d = (hit && hit_locked) ? hit_pass : 1'b1;
            end else begin
                allow_d = hit && hit_pass;
            end
        end
    end

    assign allow_o = allow_d;

    // NOTE: sequential state uses non-blocking '<='; the reset here is synchronous, so it only acts on a clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            allow_q <= 1'b0;
        end else begin
            allow_q <= allow_d;
        end
    end

    assign allow_q_o = allow_q;

endmodule

// File: tb/tb_pmp_dmp.sv
// Scoreboard bench for pmp_dmp: stimulus pushes hand-computed expectations,
// a separate monitor samples the DUT and pops/compares them.
module tb_pmp_dmp;

    localparam int unsigned PLEN       = 16;
    localparam int unsigned PMP_LEN    = 13;
    localparam int unsigned NR_ENTRIES = 4;

    localparam logic [2:0] ACC_R = 3'b001;
    localparam logic [2:0] ACC_W = 3'b010;
    localparam logic [1:0] PRIV_U = 2'd0, PRIV_S = 2'd1, PRIV_RSVD = 2'd2, PRIV_M = 2'd3;
    localparam logic [1:0] DOM0 = 2'd0, DOM1 = 2'd1, DOM2 = 2'd2, DOMI = 2'd3;

    logic                               clk;
    logic                               rst_n;
    logic [PLEN-1:0]                    addr;
    logic [2:0]                         access_type;
    logic [1:0]                         priv_lvl;
    logic [1:0]                         curdom;
    logic [NR_ENTRIES-1:0][PMP_LEN-1:0] conf_addr;
    logic [NR_ENTRIES-1:0][7:0]         pmpconf;
    logic [NR_ENTRIES-1:0][7:0]         dmpconf;
    logic                               allow;
    logic                               allow_q;

    pmp_dmp #(
        .PLEN       (PLEN),
        .PMP_LEN    (PMP_LEN),
        .NR_ENTRIES (NR_ENTRIES)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .addr_i        (addr),
        .access_type_i (access_type),
        .priv_lvl_i    (priv_lvl),
        .curdom_i      (curdom),
        .conf_addr_i   (conf_addr),
        .pmpconf_i     (pmpconf),
        .dmpconf_i     (dmpconf),
        .allow_o       (allow),
        .allow_q_o     (allow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    is_q;
        logic  exp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    event sample_ev;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // Monitor: the DUT output is valid whenever inputs are stable, so sample 1 ns after each strobe.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, e.is_q ? allow_q : allow, e.exp);
            end
        end
    end

    task automatic expect_comb(input string name, input logic exp);
        exp_t e;
        e.name = name; e.is_q = 1'b0; e.exp = exp;
        exp_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    task automatic expect_reg(input string name, input logic exp);
        exp_t e;
        e.name = name; e.is_q = 1'b1; e.exp = exp;
        exp_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_all_dom(input logic [7:0] d);
        for (int i = 0; i < NR_ENTRIES; i++) dmpconf[i] = d;
    endtask

    initial begin
        rst_n       = 1'b0;
        addr        = 16'h19BA;
        access_type = ACC_R;
        priv_lvl    = PRIV_U;
        curdom      = DOM0;
        conf_addr   = '0;
        pmpconf     = '0;
        dmpconf     = '0;

        next_cycle();
        expect_reg("reset_q", 1'b0);
        expect_comb("all_off_u", 1'b0);
        rst_n = 1'b1;

        // Entry 3: NAPOT 0x1900..0x19FF RWX owned by DOM1
        conf_addr[3] = 13'h065F; pmpconf[3] = 8'h1F; set_all_dom(8'h01);
        curdom = DOM0;
        expect_comb("e3_dom_mismatch", 1'b0);
        curdom = DOM1;
        expect_comb("e3_dom_match", 1'b1);

        // Entry 2: NAPOT 0x19B0..0x19BF no perms, outranks entry 3
        conf_addr[2] = 13'h066D; pmpconf[2] = 8'h18;
        expect_comb("e2_wins_no_r", 1'b0);

        // Entry 1: NAPOT 0x19B8..0x19BF R only, all domains DOM0
        conf_addr[1] = 13'h066E; pmpconf[1] = 8'h19; set_all_dom(8'h00);
        curdom = DOM0;
        expect_comb("e1_r_ok", 1'b1);
        next_cycle();
        expect_reg("e1_r_ok_q", 1'b1);
        addr = 16'h19B7;
        expect_comb("e2_edge_below_e1", 1'b0);
        addr = 16'h19C0;
        expect_comb("e3_above_e2", 1'b1);
        addr = 16'h18FF;
        expect_comb("below_e3_u_deny", 1'b0);

        // Entry 0: NA4 at 0x19B8, no perms
        conf_addr[0] = 13'h066E; pmpconf[0] = 8'h10;
        curdom = DOM1; addr = 16'h19B8;
        expect_comb("e0_na4_no_perm", 1'b0);
        pmpconf[0] = 8'h11; dmpconf[0] = 8'h03;
        expect_comb("e0_na4_r_domi", 1'b1);
        access_type = ACC_W;
        expect_comb("e0_na4_w_denied", 1'b0);
        access_type = ACC_R | ACC_W;
        expect_comb("e0_na4_rw_denied", 1'b0);
        access_type = ACC_R; addr = 16'h19BC;
        expect_comb("na4_miss_e1_dom", 1'b0);

        // All OFF, then a locked TOR entry checked even in M-mode
        pmpconf = '0; addr = 16'h19BA;
        priv_lvl = PRIV_M;
        expect_comb("off_m_allow", 1'b1);
        priv_lvl = PRIV_U;
        expect_comb("off_u_deny", 1'b0);
        conf_addr[0] = 13'h0680; pmpconf[0] = 8'h89; dmpconf[0] = 8'h02;
        priv_lvl = PRIV_M; curdom = DOM0;
        expect_comb("tor_locked_m_dom", 1'b0);
        curdom = DOM2;
        expect_comb("tor_locked_m_ok", 1'b1);
        addr = 16'h1A00;
        expect_comb("tor_hi_excl_m", 1'b1);
        priv_lvl = PRIV_S;
        expect_comb("tor_hi_excl_s", 1'b0);
        addr = 16'h19BA; priv_lvl = PRIV_RSVD;
        expect_comb("priv2_as_s", 1'b1);
        pmpconf[0] = 8'h09; priv_lvl = PRIV_M; curdom = DOM0;
        expect_comb("unlocked_m_allow", 1'b1);
        priv_lvl = PRIV_U;
        expect_comb("unlocked_u_dom", 1'b0);
        dmpconf[0] = 8'hFE; curdom = DOM2;
        expect_comb("dmp_rsvd_ignored", 1'b1);

        // TOR with hi <= lo never matches
        pmpconf[0] = 8'h00; conf_addr[1] = 13'h0600; pmpconf[1] = 8'h0F; dmpconf[1] = 8'h03;
        addr = 16'h1700;
        expect_comb("tor_empty_range", 1'b0);

        // NAPOT all ones covers everything
        pmpconf[1] = 8'h00; conf_addr[0] = 13'h1FFF; pmpconf[0] = 8'h1F; dmpconf[0] = 8'h03;
        addr = 16'hFFFF;
        expect_comb("napot_all_ones", 1'b1);

        // Mid-stream reset
        next_cycle();
        expect_reg("pre_reset_q", 1'b1);
        rst_n = 1'b0;
        expect_comb("comb_in_reset", 1'b1);
        next_cycle();
        expect_reg("reset_forces_q", 1'b0);
        rst_n = 1'b1;
        next_cycle();
        expect_reg("release_q", 1'b1);

        #5;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
